// File: rtl/multi_project_io_mux_if.sv
// Wishbone slave bus bundle for multi_project_io_mux.
// Signals: wbs_cyc_i/wbs_stb_i/wbs_we_i  cycle, strobe and write enable
//          wbs_sel_i[3:0]                byte selects
//          wbs_adr_i[31:0]               address (only [3:2] decoded)
//          wbs_dat_i[31:0]               write data
//          wbs_dat_o[31:0]               read data
//          wbs_ack_o                     single-cycle acknowledge
// Modports: master drives the request side, slave drives dat_o/ack.
interface multi_project_io_mux_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );
endinterface

// File: rtl/multi_project_io_mux.sv
// Multi-project IO multiplexer: hosts NUM_PROJECTS user designs behind one
// shared pad bank and connects at most one of them. Selection changes run
// a safe-switch sequence: pads isolated for GUARD_CYCLES, new project held
// in reset for RESET_CYCLES, then connected.
// Ports:
//   wb_clk_i, wb_rst_n         clock, asynchronous active-low reset
//   wb (slave modport)         Wishbone register port (CTRL/STATUS/SWITCH_COUNT)
//   io_in/io_out/io_oeb        pad bank (oeb active low)
//   proj_io_in/out/oeb         per-project pad views, project k at [k*IO_WIDTH +: IO_WIDTH]
//   proj_rst_n                 per-project active-low reset
//   proj_ena                   one-hot connected-project indicator
module multi_project_io_mux #(
    parameter int NUM_PROJECTS = 4,
    parameter int IO_WIDTH     = 38,
    parameter int GUARD_CYCLES = 16,
    parameter int RESET_CYCLES = 8
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n,
    multi_project_io_mux_if.slave            wb,
    input  logic [IO_WIDTH-1:0]              io_in,
    output logic [IO_WIDTH-1:0]              io_out,
    output logic [IO_WIDTH-1:0]              io_oeb,
    output logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_in,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_out,
    input  logic [NUM_PROJECTS*IO_WIDTH-1:0] proj_io_oeb,
    output logic [NUM_PROJECTS-1:0]          proj_rst_n,
    output logic [NUM_PROJECTS-1:0]          proj_ena
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GUARD  = 2'd2,
        ST_RESET  = 2'd3
    } state_t;

    localparam int CNT_MAX = (GUARD_CYCLES > RESET_CYCLES) ? GUARD_CYCLES : RESET_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] RESET_LOAD = CW'(RESET_CYCLES - 1);
    localparam logic [8:0]    NUM_P9     = 9'(NUM_PROJECTS);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    active_sel, active_sel_next;
    logic          switch_done;

    logic [7:0]    req_sel;
    logic          req_en;
    logic [15:0]   switch_count;
    logic          ack;
    logic [31:0]   dat;
    logic [31:0]   rd_data;

    logic          bus_req, ctrl_wr, count_clr, busy, valid, mismatch;
    logic          unused_bits;

    assign unused_bits = ^{wb.wbs_adr_i[31:4], wb.wbs_adr_i[1:0],
                           wb.wbs_dat_i[30:8], wb.wbs_sel_i[2:1]};

    // A new request is only accepted while ack is low, which yields the
    // ack-every-other-cycle behaviour for held strobes.
    assign bus_req   = wb.wbs_cyc_i && wb.wbs_stb_i && !ack;
    assign ctrl_wr   = bus_req && wb.wbs_we_i && (wb.wbs_adr_i[3:2] == 2'd0);
    assign count_clr = bus_req && wb.wbs_we_i && (wb.wbs_adr_i[3:2] == 2'd2);

    assign busy     = (state == ST_GUARD) || (state == ST_RESET);
    assign valid    = req_en && ({1'b0, req_sel} < NUM_P9);
    assign mismatch = (!valid && state != ST_IDLE) ||
                      (valid && (state == ST_IDLE || req_sel != active_sel));

    assign wb.wbs_ack_o = ack;
    assign wb.wbs_dat_o = dat;

    always_comb begin
        rd_data = '0;
        case (wb.wbs_adr_i[3:2])
            2'd0:    rd_data = {req_en, 23'b0, req_sel};
            2'd1:    rd_data = {21'b0, busy, state, active_sel};
            2'd2:    rd_data = {16'b0, switch_count};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            ack     <= 1'b0;
            dat     <= '0;
            req_sel <= '0;
            req_en  <= 1'b0;
        end else begin
            ack <= bus_req;
            dat <= bus_req ? rd_data : '0;
            if (ctrl_wr) begin
                if (wb.wbs_sel_i[0]) req_sel <= wb.wbs_dat_i[7:0];
                if (wb.wbs_sel_i[3]) req_en  <= wb.wbs_dat_i[31];
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            switch_count <= '0;
        end else if (count_clr) begin
            switch_count <= '0;
        end else if (switch_done && switch_count != '1) begin
            switch_count <= switch_count + 16'd1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            active_sel <= '0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            active_sel <= active_sel_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        active_sel_next = active_sel;
        switch_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (valid) begin
                    state_next      = ST_GUARD;
                    cnt_next        = GUARD_LOAD;
                    active_sel_next = req_sel;
                end
            end
            ST_ACTIVE: begin
                if (mismatch) begin
                    state_next = ST_GUARD;
                    cnt_next   = GUARD_LOAD;
                    if (valid) active_sel_next = req_sel;
                end
            end
            ST_GUARD: begin
                if (cnt == '0) begin
                    if (!valid) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next      = ST_RESET;
                        cnt_next        = RESET_LOAD;
                        active_sel_next = req_sel;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_RESET: begin
                if (cnt == '0) begin
                    if (valid && req_sel == active_sel) begin
                        state_next  = ST_ACTIVE;
                        switch_done = 1'b1;
                    end else begin
                        state_next = ST_GUARD;
                        cnt_next   = GUARD_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Pad routing is decoded from registered state only, so an asserted
    // reset isolates the pads without waiting for a clock edge.
    always_comb begin
        io_out     = '0;
        io_oeb     = '1;
        proj_io_in = '0;
        proj_rst_n = '0;
        proj_ena   = '0;
        for (int unsigned k = 0; k < NUM_PROJECTS; k++) begin
            if (active_sel == 8'(k)) begin
                if (state == ST_ACTIVE) begin
                    io_out                           = proj_io_out[k*IO_WIDTH +: IO_WIDTH];
                    io_oeb                           = proj_io_oeb[k*IO_WIDTH +: IO_WIDTH];
                    proj_io_in[k*IO_WIDTH +: IO_WIDTH] = io_in;
                    proj_rst_n[k]                    = 1'b1;
                    proj_ena[k]                      = 1'b1;
                end else if (state == ST_RESET) begin
                    proj_io_in[k*IO_WIDTH +: IO_WIDTH] = io_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_project_io_mux.sv
// Directed self-checking bench for multi_project_io_mux (4 projects, 38 pads,
// 16 guard cycles, 8 reset cycles).
module tb_multi_project_io_mux;

    localparam int NP = 4;
    localparam int W  = 38;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0]    io_in = '0;
    logic [W-1:0]    io_out, io_oeb;
    logic [NP*W-1:0] proj_io_in, proj_io_out, proj_io_oeb;
    logic [NP-1:0]   proj_rst_n, proj_ena;

    int  checks = 0;
    int  passes = 0;
    bit  seen_p3 = 1'b0;

    multi_project_io_mux_if bus();

    multi_project_io_mux #(
        .NUM_PROJECTS(NP),
        .IO_WIDTH(W),
        .GUARD_CYCLES(16),
        .RESET_CYCLES(8)
    ) dut (
        .wb_clk_i(clk),
        .wb_rst_n(rst_n),
        .wb(bus),
        .io_in(io_in),
        .io_out(io_out),
        .io_oeb(io_oeb),
        .proj_io_in(proj_io_in),
        .proj_io_out(proj_io_out),
        .proj_io_oeb(proj_io_oeb),
        .proj_rst_n(proj_rst_n),
        .proj_ena(proj_ena)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pat_out(int k);
        return {6'(k + 1), 32'h1111_1111 * 32'(k + 1)};
    endfunction

    function automatic logic [W-1:0] pat_oeb(int k);
        return {6'h2A ^ 6'(k), 32'hF0F0_0000 | 32'(k)};
    endfunction

    function automatic logic [NP*W-1:0] exp_pin(int k);
        logic [NP*W-1:0] v;
        v = '0;
        v[k*W +: W] = io_in;
        return v;
    endfunction

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
        bit got;
        @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = wdat;
        bus.wbs_sel_i = sel;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o) got = 1'b1;
        end
        rdat = bus.wbs_dat_o;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        checks++;
        if (!got) $display("FAIL wb_ack_timeout: adr=%h no ack within 8 cycles", adr);
        else passes++;
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] d;
        wb_xfer(1'b1, adr, wdat, 4'hF, d);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        wb_xfer(1'b0, adr, 32'h0, 4'hF, rdat);
    endtask

    task automatic poll_state(input logic [1:0] want, output logic [31:0] st);
        bit ok;
        ok = 1'b0;
        st = '0;
        for (int i = 0; i < 100 && !ok; i++) begin
            wb_read(32'h4, st);
            if (proj_ena == 4'b1000) seen_p3 = 1'b1;
            if (st[9:8] == want) ok = 1'b1;
        end
        checks++;
        if (!ok) $display("FAIL poll_state: last status=%h never reached state %0d", st, want);
        else passes++;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        bit ack_seen;
        rst_n = 1'b0;
        step(3);
        checks++;
        if ({io_oeb, io_out, proj_rst_n, proj_ena, bus.wbs_ack_o} !== {{W{1'b1}}, {W{1'b0}}, 4'b0, 4'b0, 1'b0})
            $display("FAIL reset_outputs: oeb=%h out=%h rst_n=%b ena=%b ack=%b", io_oeb, io_out, proj_rst_n, proj_ena, bus.wbs_ack_o);
        else passes++;
        checks++;
        if (proj_io_in !== '0) $display("FAIL reset_proj_io_in: got %h expected 0", proj_io_in);
        else passes++;
        rst_n = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        ack_seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            if (bus.wbs_ack_o) ack_seen = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0;
        checks++;
        if (ack_seen !== 1'b0) $display("FAIL no_ack_without_stb: got ack=1 expected 0");
        else passes++;
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0) $display("FAIL reset_status: got %h expected 00000000", d);
        else passes++;
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h expected 00000000", d);
        else passes++;
    endtask

    task automatic test_first_connect();
        logic [31:0] d;
        bit bad;
        io_in = {6'h15, 32'hDEAD_BEEF};
        wb_write(32'h0, 32'h8000_0002);
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0000_0602) $display("FAIL busy_status: got %h expected 00000602", d);
        else passes++;
        bad = 1'b0;
        for (int c = 3; c <= 24; c++) begin
            step(1);
            if (proj_ena !== 4'b0 || io_oeb !== {W{1'b1}} || proj_rst_n !== 4'b0) bad = 1'b1;
            if (c == 20) begin
                checks++;
                if (proj_io_in !== exp_pin(2)) $display("FAIL reset_phase_input: got %h expected %h", proj_io_in, exp_pin(2));
                else passes++;
            end
        end
        checks++;
        if (bad) $display("FAIL first_isolation: pads or project enabled before 25 cycles");
        else passes++;
        step(1);
        checks++;
        if ({proj_ena, proj_rst_n} !== {4'b0100, 4'b0100})
            $display("FAIL first_connect_ena: ena=%b rst_n=%b expected 0100/0100", proj_ena, proj_rst_n);
        else passes++;
        checks++;
        if ({io_out, io_oeb} !== {pat_out(2), pat_oeb(2)})
            $display("FAIL first_connect_pads: out=%h oeb=%h expected %h %h", io_out, io_oeb, pat_out(2), pat_oeb(2));
        else passes++;
        checks++;
        if (proj_io_in !== exp_pin(2)) $display("FAIL first_connect_in: got %h expected %h", proj_io_in, exp_pin(2));
        else passes++;
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0000_0102) $display("FAIL active_status: got %h expected 00000102", d);
        else passes++;
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h1) $display("FAIL switch_count_1: got %h expected 00000001", d);
        else passes++;
    endtask

    task automatic test_switch();
        logic [31:0] d;
        int held;
        bit bad;
        io_in = {6'h2B, 32'h1234_5678};
        wb_write(32'h0, 32'h8000_0001);
        checks++;
        if (proj_ena !== 4'b0100) $display("FAIL switch_still_old: ena=%b expected 0100", proj_ena);
        else passes++;
        step(1);
        checks++;
        if ({io_oeb, io_out, proj_rst_n, proj_ena} !== {{W{1'b1}}, {W{1'b0}}, 4'b0, 4'b0})
            $display("FAIL switch_guard_iso: oeb=%h out=%h rst_n=%b ena=%b", io_oeb, io_out, proj_rst_n, proj_ena);
        else passes++;
        held = 0;
        bad = 1'b0;
        for (int c = 2; c <= 24; c++) begin
            step(1);
            if (proj_ena !== 4'b0 || io_oeb !== {W{1'b1}}) bad = 1'b1;
            if (proj_rst_n === 4'b0 && proj_io_in === exp_pin(1)) held++;
        end
        checks++;
        if (bad) $display("FAIL switch_isolation: pads driven during switch");
        else passes++;
        checks++;
        if (held != 8) $display("FAIL switch_reset_len: got %0d expected 8", held);
        else passes++;
        step(1);
        checks++;
        if ({proj_ena, proj_rst_n, io_out} !== {4'b0010, 4'b0010, pat_out(1)})
            $display("FAIL switch_connect: ena=%b rst_n=%b out=%h", proj_ena, proj_rst_n, io_out);
        else passes++;
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h2) $display("FAIL switch_count_2: got %h expected 00000002", d);
        else passes++;
    endtask

    task automatic test_retarget();
        logic [31:0] d;
        seen_p3 = 1'b0;
        wb_write(32'h0, 32'h8000_0002);
        wb_write(32'h0, 32'h8000_0003);
        poll_state(2'd3, d);
        checks++;
        if (d !== 32'h0000_0703) $display("FAIL retarget_reset3: got %h expected 00000703", d);
        else passes++;
        wb_write(32'h0, 32'h8000_0000);
        poll_state(2'd2, d);
        checks++;
        if (d !== 32'h0000_0603) $display("FAIL retarget_back_to_guard: got %h expected 00000603", d);
        else passes++;
        poll_state(2'd1, d);
        checks++;
        if (d !== 32'h0000_0100) $display("FAIL retarget_active0: got %h expected 00000100", d);
        else passes++;
        checks++;
        if ({proj_ena, proj_rst_n, io_out} !== {4'b0001, 4'b0001, pat_out(0)})
            $display("FAIL retarget_connect: ena=%b rst_n=%b out=%h", proj_ena, proj_rst_n, io_out);
        else passes++;
        checks++;
        if (seen_p3) $display("FAIL retarget_p3_seen: got 1 expected 0");
        else passes++;
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h3) $display("FAIL switch_count_3: got %h expected 00000003", d);
        else passes++;
    endtask

    task automatic test_registers();
        logic [31:0] d;
        logic [31:0] r;
        wb_xfer(1'b1, 32'h0, 32'hFFFF_FF01, 4'b0001, r);
        poll_state(2'd1, d);
        checks++;
        if (d !== 32'h0000_0101) $display("FAIL byte_lane_select: got %h expected 00000101", d);
        else passes++;
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h8000_0001) $display("FAIL ctrl_readback: got %h expected 80000001", d);
        else passes++;
        wb_write(32'h0, 32'h8000_0001);
        step(3);
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0000_0101 || proj_ena !== 4'b0010)
            $display("FAIL same_sel_no_switch: status=%h ena=%b expected 00000101/0010", d, proj_ena);
        else passes++;
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h4) $display("FAIL switch_count_4: got %h expected 00000004", d);
        else passes++;
        wb_write(32'h8, 32'h1234_0000);
        wb_read(32'h8, d);
        checks++;
        if (d !== 32'h0) $display("FAIL count_clear: got %h expected 00000000", d);
        else passes++;
        wb_write(32'hC, 32'hFFFF_FFFF);
        wb_read(32'hC, d);
        checks++;
        if (d !== 32'h0) $display("FAIL reg3_read: got %h expected 00000000", d);
        else passes++;
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h8000_0001) $display("FAIL reg3_write_ignored: ctrl=%h expected 80000001", d);
        else passes++;
    endtask

    task automatic test_disconnect();
        logic [31:0] d;
        wb_write(32'h0, 32'h8000_0009);
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0000_0601) $display("FAIL out_of_range_guard: got %h expected 00000601", d);
        else passes++;
        poll_state(2'd0, d);
        checks++;
        if (d !== 32'h0000_0001) $display("FAIL out_of_range_idle: got %h expected 00000001", d);
        else passes++;
        checks++;
        if ({io_oeb, io_out, proj_rst_n, proj_ena} !== {{W{1'b1}}, {W{1'b0}}, 4'b0, 4'b0} || proj_io_in !== '0)
            $display("FAIL idle_isolation: oeb=%h out=%h rst_n=%b ena=%b", io_oeb, io_out, proj_rst_n, proj_ena);
        else passes++;
        wb_write(32'h0, 32'h8000_0000);
        poll_state(2'd1, d);
        wb_write(32'h0, 32'h0000_0001);
        poll_state(2'd0, d);
        checks++;
        if (d !== 32'h0000_0000 || proj_rst_n !== 4'b0 || proj_ena !== 4'b0)
            $display("FAIL disable_idle: status=%h rst_n=%b ena=%b", d, proj_rst_n, proj_ena);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [5:0] acks;
        @(posedge clk);
        #1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = 32'h4;
        for (int i = 5; i >= 0; i--) begin
            step(1);
            acks[i] = bus.wbs_ack_o;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        step(1);
        checks++;
        if (acks !== 6'b101010) $display("FAIL back_to_back_ack: got %b expected 101010", acks);
        else passes++;
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        wb_write(32'h0, 32'h8000_0002);
        poll_state(2'd3, d);
        checks++;
        if (proj_io_in !== exp_pin(2)) $display("FAIL pre_reset_input: got %h expected %h", proj_io_in, exp_pin(2));
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({io_oeb, io_out, proj_rst_n, proj_ena, bus.wbs_ack_o} !== {{W{1'b1}}, {W{1'b0}}, 4'b0, 4'b0, 1'b0} || proj_io_in !== '0)
            $display("FAIL async_reset: oeb=%h in=%h rst_n=%b ena=%b", io_oeb, proj_io_in, proj_rst_n, proj_ena);
        else passes++;
        step(2);
        rst_n = 1'b1;
        step(1);
        wb_read(32'h0, d);
        checks++;
        if (d !== 32'h0) $display("FAIL ctrl_after_reset: got %h expected 00000000", d);
        else passes++;
        wb_read(32'h4, d);
        checks++;
        if (d !== 32'h0) $display("FAIL status_after_reset: got %h expected 00000000", d);
        else passes++;
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        for (int k = 0; k < NP; k++) begin
            proj_io_out[k*W +: W] = pat_out(k);
            proj_io_oeb[k*W +: W] = pat_oeb(k);
        end
        test_reset();
        test_first_connect();
        test_switch();
        test_retarget();
        test_registers();
        test_disconnect();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
